// File: rtl/zzcpu_pkg.sv
// Shared definitions for the zzcpu register heap and its write-port control.
// Holds the heap geometry (address width, data width, register count) and
// the grant encoding used by the writeback arbiter.
package zzcpu_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 16;
    localparam int NUM_REGS   = 16;

    // Which writeback requester owns the heap write port this cycle
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_A    = 2'd1,
        GRANT_B    = 2'd2
    } grant_e;

endpackage

// File: rtl/regheap_scoreboard.sv
// Per-register pending-write scoreboard for the register heap.
// Each register has a saturating up/down counter of outstanding writes:
// issues count up, heap commits count down.
// Ports:
//   CLK, RST        - clock, async active-high reset
//   issue_i         - decode issues a writer of issue_reg_i
//   issue_reg_i     - destination register of the issue
//   commit_i        - heap commits a write this edge
//   commit_reg_i    - register being committed
//   rdreg1_i/2_i    - decode source registers
//   issue_ready_o   - issue accepted (counter not saturated, or freed by commit)
//   hazard1_o/2_o   - source register has a pending write
module regheap_scoreboard
    import zzcpu_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  issue_i,
    input  logic [REG_ADDR_W-1:0] issue_reg_i,
    input  logic                  commit_i,
    input  logic [REG_ADDR_W-1:0] commit_reg_i,
    input  logic [REG_ADDR_W-1:0] rdreg1_i,
    input  logic [REG_ADDR_W-1:0] rdreg2_i,
    output logic                  issue_ready_o,
    output logic                  hazard1_o,
    output logic                  hazard2_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt [NUM_REGS];

    // A full counter can still accept an issue when a commit to the same
    // register frees a slot on the same edge; the net count is unchanged.
    always_comb begin
        issue_ready_o = (cnt[issue_reg_i] != CNT_MAX)
                      || (commit_i && (commit_reg_i == issue_reg_i));
        hazard1_o     = (cnt[rdreg1_i] != '0);
        hazard2_o     = (cnt[rdreg2_i] != '0);
    end

    // Counter update. Commits to a register with nothing pending (an
    // unissued write) leave the counter at zero rather than wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                logic inc;
                logic dec;
                inc = issue_i && issue_ready_o && (issue_reg_i == REG_ADDR_W'(r));
                dec = commit_i && (commit_reg_i == REG_ADDR_W'(r));
                if (inc && !dec) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec && !inc && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regheap_wb_arbiter.sv
// Write-port controller for the 16x16-bit register heap.
// Arbitrates the single heap write port between the ALU writeback (A) and
// the load return (B), registers the winning write toward the heap, and
// tracks pending writes so decode can stall on read-after-write hazards.
// Ports:
//   CLK, RST                      - clock, async active-high reset
//   issue_i/issue_reg_i           - decode issue of a register writer
//   issue_ready_o                 - issue accepted this cycle
//   a_valid_i/a_reg_i/a_data_i    - ALU writeback request
//   a_ready_o                     - ALU granted
//   b_valid_i/b_reg_i/b_data_i    - load writeback request
//   b_ready_o                     - load granted
//   rdreg1_i/rdreg2_i             - decode source registers
//   hazard1_o/hazard2_o           - pending write on a source register
//   regwrite_o/wrreg_o/wdata_o    - heap write port
module regheap_wb_arbiter
    import zzcpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  issue_i,
    input  logic [REG_ADDR_W-1:0] issue_reg_i,
    output logic                  issue_ready_o,
    input  logic                  a_valid_i,
    input  logic [REG_ADDR_W-1:0] a_reg_i,
    input  logic [DATA_W-1:0]     a_data_i,
    output logic                  a_ready_o,
    input  logic                  b_valid_i,
    input  logic [REG_ADDR_W-1:0] b_reg_i,
    input  logic [DATA_W-1:0]     b_data_i,
    output logic                  b_ready_o,
    input  logic [REG_ADDR_W-1:0] rdreg1_i,
    input  logic [REG_ADDR_W-1:0] rdreg2_i,
    output logic                  hazard1_o,
    output logic                  hazard2_o,
    output logic                  regwrite_o,
    output logic [REG_ADDR_W-1:0] wrreg_o,
    output logic [DATA_W-1:0]     wdata_o
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    grant_e     grant;

    // Loads win by default since they retire long-latency work; once the
    // ALU has been passed over STARVE_LIMIT times in a row it is forced in.
    always_comb begin
        grant = GRANT_NONE;
        if (b_valid_i && !(a_valid_i && (starve_cnt == STARVE_MAX))) begin
            grant = GRANT_B;
        end else if (a_valid_i) begin
            grant = GRANT_A;
        end
        a_ready_o = (grant == GRANT_A);
        b_ready_o = (grant == GRANT_B);
    end

    // Starvation tracking. Counts only while A is waiting behind B; any
    // A grant or A withdrawing its request starts the count over. The
    // forced A grant at the limit keeps it from ever passing STARVE_LIMIT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (a_valid_i && (grant == GRANT_B)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Write launch. The winner's write is presented to the heap for one
    // cycle; address and data hold when idle so the heap port stays quiet.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            regwrite_o <= 1'b0;
            wrreg_o    <= '0;
            wdata_o    <= '0;
        end else begin
            case (grant)
                GRANT_A: begin
                    regwrite_o <= 1'b1;
                    wrreg_o    <= a_reg_i;
                    wdata_o    <= a_data_i;
                end
                GRANT_B: begin
                    regwrite_o <= 1'b1;
                    wrreg_o    <= b_reg_i;
                    wdata_o    <= b_data_i;
                end
                default: begin
                    regwrite_o <= 1'b0;
                end
            endcase
        end
    end

    // The heap commits the registered write on the next edge, which is
    // exactly when the pending count for that register should drop.
    regheap_scoreboard #(
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .CLK           (CLK),
        .RST           (RST),
        .issue_i       (issue_i),
        .issue_reg_i   (issue_reg_i),
        .commit_i      (regwrite_o),
        .commit_reg_i  (wrreg_o),
        .rdreg1_i      (rdreg1_i),
        .rdreg2_i      (rdreg2_i),
        .issue_ready_o (issue_ready_o),
        .hazard1_o     (hazard1_o),
        .hazard2_o     (hazard2_o)
    );

endmodule

// File: tb/tb_regheap_wb_arbiter.sv
// Directed bench for regheap_wb_arbiter. A behavioural model of the
// arbiter, starvation counter and per-register pending counts predicts
// every ready/hazard output; granted writes are queued and popped when
// the heap write is expected to appear.
module tb_regheap_wb_arbiter;

    localparam int LIMIT   = 4;
    localparam int CNT_MAX = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        issue_i = 1'b0;
    logic [3:0]  issue_reg_i = '0;
    logic        issue_ready_o;
    logic        a_valid_i = 1'b0;
    logic [3:0]  a_reg_i = '0;
    logic [15:0] a_data_i = '0;
    logic        a_ready_o;
    logic        b_valid_i = 1'b0;
    logic [3:0]  b_reg_i = '0;
    logic [15:0] b_data_i = '0;
    logic        b_ready_o;
    logic [3:0]  rdreg1_i = '0;
    logic [3:0]  rdreg2_i = '0;
    logic        hazard1_o;
    logic        hazard2_o;
    logic        regwrite_o;
    logic [3:0]  wrreg_o;
    logic [15:0] wdata_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_cnt [16];
    int          m_starve;
    logic        m_regwrite;
    logic [3:0]  m_wrreg;
    logic [19:0] exp_q [$];

    regheap_wb_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .CNT_W        (2)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .issue_i       (issue_i),
        .issue_reg_i   (issue_reg_i),
        .issue_ready_o (issue_ready_o),
        .a_valid_i     (a_valid_i),
        .a_reg_i       (a_reg_i),
        .a_data_i      (a_data_i),
        .a_ready_o     (a_ready_o),
        .b_valid_i     (b_valid_i),
        .b_reg_i       (b_reg_i),
        .b_data_i      (b_data_i),
        .b_ready_o     (b_ready_o),
        .rdreg1_i      (rdreg1_i),
        .rdreg2_i      (rdreg2_i),
        .hazard1_o     (hazard1_o),
        .hazard2_o     (hazard2_o),
        .regwrite_o    (regwrite_o),
        .wrreg_o       (wrreg_o),
        .wdata_o       (wdata_o)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        m_starve   = 0;
        m_regwrite = 1'b0;
        m_wrreg    = '0;
        exp_q.delete();
    endtask

    // One clock cycle: drive at the falling edge, check combinational
    // outputs, then check the heap write port just after the rising edge.
    task automatic applyStimulus(
        input logic iss, input logic [3:0] ireg,
        input logic av, input logic [3:0] areg, input logic [15:0] adata,
        input logic bv, input logic [3:0] breg, input logic [15:0] bdata,
        input logic [3:0] r1, input logic [3:0] r2);
        logic gb, ga, iready;
        logic [19:0] item;
        issue_i = iss; issue_reg_i = ireg;
        a_valid_i = av; a_reg_i = areg; a_data_i = adata;
        b_valid_i = bv; b_reg_i = breg; b_data_i = bdata;
        rdreg1_i = r1; rdreg2_i = r2;
        #1;
        gb     = bv && !(av && (m_starve == LIMIT));
        ga     = av && !gb;
        iready = (m_cnt[ireg] != CNT_MAX) || (m_regwrite && (m_wrreg == ireg));
        checkOutput("a_ready", a_ready_o, ga);
        checkOutput("b_ready", b_ready_o, gb);
        checkOutput("issue_ready", issue_ready_o, iready);
        checkOutput("hazard1", hazard1_o, m_cnt[r1] != 0);
        checkOutput("hazard2", hazard2_o, m_cnt[r2] != 0);
        if (gb) exp_q.push_back({breg, bdata});
        else if (ga) exp_q.push_back({areg, adata});
        @(posedge CLK);
        for (int r = 0; r < 16; r++) begin
            logic inc, dec;
            inc = iss && iready && (ireg == 4'(r));
            dec = m_regwrite && (m_wrreg == 4'(r));
            if (inc && !dec) m_cnt[r]++;
            else if (dec && !inc && m_cnt[r] != 0) m_cnt[r]--;
        end
        m_starve   = (av && gb) ? m_starve + 1 : 0;
        m_regwrite = ga || gb;
        #1;
        checkOutput("regwrite", regwrite_o, m_regwrite);
        if (m_regwrite) begin
            if (exp_q.size() == 0) begin
                checkOutput("queue_underrun", 1, 0);
            end else begin
                item    = exp_q.pop_front();
                m_wrreg = item[19:16];
                checkOutput("wrreg", wrreg_o, item[19:16]);
                checkOutput("wdata", wdata_o, item[15:0]);
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle(input logic [3:0] r1, input logic [3:0] r2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        modelReset();
        RST = 1'b1;
        #12;
        checkOutput("rst_regwrite", regwrite_o, 0);
        checkOutput("rst_wrreg", wrreg_o, 0);
        checkOutput("rst_wdata", wdata_o, 0);
        checkOutput("rst_hazard1", hazard1_o, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Single ALU write to reg 8: hazard spans issue to commit
        applyStimulus(1, 8, 0, 0, 0, 0, 0, 0, 8, 0);
        applyStimulus(0, 0, 1, 8, 16'hF0F0, 0, 0, 0, 8, 0);
        idle(8, 0);
        idle(8, 0);
        checkOutput("reg8_clear", hazard1_o, 0);

        // Contention: B wins LIMIT times, then A is forced in
        for (int i = 0; i < LIMIT + 2; i++) begin
            applyStimulus(0, 0, 1, 3, 16'hABCD, 1, 9, 16'hDDDD, 3, 9);
        end
        idle(0, 0);
        idle(0, 0);

        // Saturation of reg 5, then a commit frees a slot on the same edge
        for (int i = 0; i < CNT_MAX + 1; i++) begin
            applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 5, 0);
        end
        checkOutput("sat_blocked", issue_ready_o, 0);
        applyStimulus(1, 5, 1, 5, 16'h5555, 0, 0, 0, 5, 0);
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 5, 0);
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 5, 0);
        checkOutput("sat_after_commit", issue_ready_o, 0);
        for (int i = 0; i < CNT_MAX; i++) begin
            applyStimulus(0, 0, 1, 5, 16'h0500 + 16'(i), 0, 0, 0, 5, 0);
        end
        idle(5, 0);
        idle(5, 0);
        checkOutput("reg5_drained", hazard1_o, 0);

        // Simultaneous issue and commit on reg 9 with one pending
        applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 9);
        applyStimulus(0, 0, 0, 0, 0, 1, 9, 16'h9999, 0, 9);
        applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 9);
        idle(0, 9);
        checkOutput("reg9_still_pending", hazard2_o, 1);

        // Unissued write to reg 2 must not underflow
        applyStimulus(0, 0, 1, 2, 16'h2222, 0, 0, 0, 2, 0);
        idle(2, 0);
        idle(2, 0);
        checkOutput("reg2_no_underflow", hazard1_o, 0);

        // Reset while a write to reg 8 is on the heap port
        applyStimulus(1, 8, 0, 0, 0, 0, 0, 0, 8, 0);
        applyStimulus(0, 0, 1, 8, 16'h8888, 0, 0, 0, 8, 0);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("midrst_regwrite", regwrite_o, 0);
        checkOutput("midrst_wrreg", wrreg_o, 0);
        checkOutput("midrst_hazard1", hazard1_o, 0);
        checkOutput("midrst_hazard2", hazard2_o, 0);
        modelReset();
        @(negedge CLK);
        RST = 1'b0;
        idle(8, 9);
        applyStimulus(1, 8, 0, 0, 0, 0, 0, 0, 8, 0);

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regheap_wb_arbiter.md
Name: regheap_wb_arbiter

Overview:
Write-port controller for the 16x16-bit RegisterHeap. Shares the heap's single write port between two writeback requesters: ALU result (A) and memory load return (B). Keeps a per-register pending-write scoreboard so decode can stall on read-after-write hazards. Sits between the EX/MEM writeback sources and the heap's regwrite_i/wrreg_i/wdata_i inputs.

Parameters:
STARVE_LIMIT, 4, consecutive cycles A may be denied by B before A is forced to win (1..15)
CNT_W, 2, width of each per-register pending counter; maximum count is 2^CNT_W-1

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-high
issue_i  in  1  decode issues an instruction that will write issue_reg_i
issue_reg_i  in  4  destination register of the issued instruction
issue_ready_o  out  1  issue accepted this cycle; low when issue_reg_i counter is saturated
a_valid_i  in  1  ALU writeback request
a_reg_i  in  4  ALU destination register
a_data_i  in  16  ALU result
a_ready_o  out  1  ALU request granted this cycle
b_valid_i  in  1  load writeback request
b_reg_i  in  4  load destination register
b_data_i  in  16  load data
b_ready_o  out  1  load request granted this cycle
rdreg1_i  in  4  decode source register 1 (same value driven to heap)
rdreg2_i  in  4  decode source register 2
hazard1_o  out  1  rdreg1_i has a write pending
hazard2_o  out  1  rdreg2_i has a write pending
regwrite_o  out  1  to heap regwrite_i
wrreg_o  out  4  to heap wrreg_i
wdata_o  out  16  to heap wdata_i

Behaviour:
- Reset (async, RST=1): regwrite_o=0, wrreg_o=0, wdata_o=0, all 16 counters=0, starve counter=0; hazard1_o/hazard2_o=0; ready outputs follow combinational rules on zeroed state. Reset mid-operation drops any in-flight write (regwrite_o falls immediately) and discards all pending counts.
- Arbitration (combinational, each cycle): only B valid -> B; only A valid -> A; both valid -> B, unless starve_cnt==STARVE_LIMIT, then A. a_ready_o/b_ready_o high only for the winner. Valid may drop without a grant (no hold requirement).
- Starve counter: +1 on each edge where A and B are valid and B wins; cleared on A grant or when A is not valid; never exceeds STARVE_LIMIT.
- Write launch: on the edge that ends a grant cycle N, regwrite_o<=1, wrreg_o/wdata_o <= winner's reg/data. With no grant, regwrite_o<=0 and wrreg_o/wdata_o hold. Heap commits at the end of cycle N+1, giving a fixed latency of 2 edges from grant to data in the heap.
- Scoreboard: cnt[r] +1 on an edge with issue_i & issue_ready_o & issue_reg_i==r. cnt[r] -1 on an edge with regwrite_o & wrreg_o==r (the heap commit edge).
- Simultaneous increment and decrement on the same r: net 0.
- issue_ready_o = (cnt[issue_reg_i] != max) OR (regwrite_o & wrreg_o==issue_reg_i).
- A decrement when cnt==0 (unissued write) leaves cnt at 0; the write still proceeds.
- Hazards: hazard1_o = cnt[rdreg1_i]!=0; hazard2_o likewise. Combinational from registered state, so the hazard clears in the first cycle after the heap commit edge, when the heap read returns the new value.
- Requesters A and B may target the same register; grant order defines the final value.

Decomposition:
- Shared package (zzcpu_pkg): REG_ADDR_W=4, DATA_W=16, NUM_REGS=16.
- One sub-module, regheap_scoreboard: 16 saturating up/down counters, issue_ready_o and the two hazard outputs.
- Arbiter and write-launch registers stay in the top module.

Test Plan:
- Reset: RST pulse mid-write (regwrite_o=1, wrreg_o=8) -> regwrite_o=0 at once; all counters=0; hazard1_o=0 for rdreg1_i=8.
- Single ALU write: issue reg 8, then A valid reg 8 / 16'hF0F0 -> a_ready_o=1; next cycle regwrite_o=1, wrreg_o=8, wdata_o=16'hF0F0; hazard1_o (rdreg1_i=8) high until the commit edge, then 0; heap read = F0F0.
- Contention: A (reg 3, 16'hABCD) and B (reg 9, 16'hDDDD) both valid continuously -> B wins 4 cycles, A wins the 5th (STARVE_LIMIT=4); starve counter then back to 0.
- Saturation: issue reg 5 three times with no writes -> issue_ready_o=0 on the 4th attempt. Same cycle with a commit to reg 5 -> issue_ready_o=1 and count stays 3.
- Simultaneous issue and commit to reg 9 with cnt=1 -> cnt stays 1; hazard2_o (rdreg2_i=9) remains 1.
- Unissued write to reg 2 with cnt=0 -> heap written, cnt stays 0, no underflow.
